// File: rtl/cp0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_pkg                                                              |
// | Shared register select codes, field positions and packing helpers    |
// | for the CP0 coprocessor.                                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cp0_pkg;

    localparam logic [4:0] c_sel_count   = 5'd9;
    localparam logic [4:0] c_sel_compare = 5'd11;
    localparam logic [4:0] c_sel_sr      = 5'd12;
    localparam logic [4:0] c_sel_cause   = 5'd13;
    localparam logic [4:0] c_sel_epc     = 5'd14;
    localparam logic [4:0] c_sel_prid    = 5'd15;

    localparam int c_sr_ie_bit     = 0;
    localparam int c_sr_exl_bit    = 1;
    localparam int c_sr_im_lsb     = 8;
    localparam int c_cause_exc_lsb = 2;
    localparam int c_cause_ip_lsb  = 8;
    localparam int c_ip_timer_bit  = 7;

    localparam logic [4:0] c_exc_int = 5'd0;

    function automatic logic [31:0] pack_sr(input logic [7:0] im,
                                            input logic       exl,
                                            input logic       ie);
        return {16'b0, im, 6'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic [7:0] ip,
                                               input logic [4:0] exccode);
        return {16'b0, ip, 1'b0, exccode, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_timer                                                            |
// | Free-running Count register with Compare match and sticky pending.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cp0_timer #(
    parameter int TIMER_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_compare    <= '1;
            r_timer_pend <= 1'b0;
        end else begin
            r_count <= wr_count ? din : r_count + 32'd1;
            if (wr_compare) begin
                r_compare <= din;
            end
            // A Compare write acknowledges the timer even if it matches this cycle.
            if (wr_compare) begin
                r_timer_pend <= 1'b0;
            end else if ((TIMER_EN != 0) && (r_count == r_compare)) begin
                r_timer_pend <= 1'b1;
            end
        end
    end

    assign count      = r_count;
    assign compare    = r_compare;
    assign timer_pend = r_timer_pend;

endmodule
`default_nettype wire

// File: rtl/cp0_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_v2                                                               |
// | CP0 coprocessor: SR/Cause/EPC/PrID, interrupt gating, timer.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cp0_v2
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h2007_4411,
    parameter int          TIMER_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc,
    input  logic [31:0]          din,
    input  logic [4:0]           sel,
    input  logic                 wen,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 exc_req,
    input  logic [4:0]           exc_code,
    input  logic                 eret,
    output logic                 int_req,
    output logic                 exl,
    output logic [31:0]          epc,
    output logic [31:0]          dout
);

    logic [7:0]  r_im;
    logic [7:0]  r_ip;
    logic        r_ie;
    logic        r_exl;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_wr_sr;
    logic        w_wr_epc;
    logic        w_entry;
    logic [7:0]  w_ip_next;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_pend;
    logic [1:0]  w_unused;

    assign w_unused = pc[1:0];
    assign w_wr_sr  = wen && (sel == c_sel_sr);
    assign w_wr_epc = wen && (sel == c_sel_epc);

    cp0_timer #(
        .TIMER_EN (TIMER_EN)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_count   (wen && (sel == c_sel_count)),
        .wr_compare (wen && (sel == c_sel_compare)),
        .din        (din),
        .count      (w_count),
        .compare    (w_compare),
        .timer_pend (w_timer_pend)
    );

    // Interrupt request is derived only from registered state.
    assign int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign w_entry = exc_req | int_req;

    always_comb begin
        w_ip_next                 = '0;
        w_ip_next[NUM_HWINT-1:0]  = hwint;
        w_ip_next[c_ip_timer_bit] = w_timer_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_im      <= '0;
            r_ip      <= '0;
            r_ie      <= 1'b0;
            r_exl     <= 1'b0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= w_ip_next;
            if (w_wr_sr) begin
                r_im <= din[15:8];
                r_ie <= din[c_sr_ie_bit];
            end
            // Entry dominates both SR writes and eret for the EXL flag.
            if (w_entry) begin
                r_exl <= 1'b1;
            end else if (w_wr_sr) begin
                r_exl <= din[c_sr_exl_bit];
            end else if (eret) begin
                r_exl <= 1'b0;
            end
            if (w_entry) begin
                r_epc <= {pc[31:2], 2'b00};
            end else if (w_wr_epc) begin
                r_epc <= {din[31:2], 2'b00};
            end
            if (w_entry) begin
                r_exccode <= exc_req ? exc_code : c_exc_int;
            end
        end
    end

    always_comb begin
        dout = '0;
        case (sel)
            c_sel_count:   dout = w_count;
            c_sel_compare: dout = w_compare;
            c_sel_sr:      dout = pack_sr(r_im, r_exl, r_ie);
            c_sel_cause:   dout = pack_cause(r_ip, r_exccode);
            c_sel_epc:     dout = r_epc;
            c_sel_prid:    dout = PRID_VAL;
            default:       dout = '0;
        endcase
    end

    assign exl = r_exl;
    assign epc = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cp0_v2                                                            |
// | Self-checking bench: vector table, directed sequences, random run.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cp0_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, din;
    logic [4:0]  sel, exc_code;
    logic        wen, exc_req, eret;
    logic [5:0]  hwint;
    logic        int_req, exl;
    logic [31:0] epc, dout;

    logic [31:0] din2;
    logic [4:0]  sel2;
    logic        wen2;
    logic [2:0]  hwint2;
    logic        int_req2, exl2;
    logic [31:0] epc2, dout2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_v2 dut (
        .clk(clk), .rst(rst), .pc(pc), .din(din), .sel(sel), .wen(wen),
        .hwint(hwint), .exc_req(exc_req), .exc_code(exc_code), .eret(eret),
        .int_req(int_req), .exl(exl), .epc(epc), .dout(dout)
    );

    cp0_v2 #(.NUM_HWINT(3), .TIMER_EN(0)) dut2 (
        .clk(clk), .rst(rst), .pc(32'h0), .din(din2), .sel(sel2), .wen(wen2),
        .hwint(hwint2), .exc_req(1'b0), .exc_code(5'd0), .eret(1'b0),
        .int_req(int_req2), .exl(exl2), .epc(epc2), .dout(dout2)
    );

    // Reference state of the architectural registers.
    logic [7:0]  m_im, m_ip;
    logic        m_ie, m_exl, m_tp;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_count, m_compare;

    function automatic logic model_int();
        return ((m_ip & m_im) != 8'h00) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] s);
        case (s)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_ip, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            5'd15:   return 32'h2007_4411;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic entry;
        logic wc;
        logic [7:0] ipn;
        if (rst) begin
            m_im = 0; m_ip = 0; m_ie = 0; m_exl = 0; m_exc = 0; m_epc = 0;
            m_count = 0; m_compare = 32'hFFFF_FFFF; m_tp = 0;
        end else begin
            entry = exc_req || model_int();
            wc    = wen && sel == 5'd11;
            ipn   = {m_tp, 1'b0, hwint};
            m_tp  = wc ? 1'b0 : (m_tp || m_count == m_compare);
            m_count = (wen && sel == 5'd9) ? din : m_count + 1;
            if (wc) m_compare = din;
            if (entry) begin
                m_exl = 1;
                m_epc = pc & ~32'd3;
                m_exc = exc_req ? exc_code : 5'd0;
            end else begin
                if (wen && sel == 5'd12) m_exl = din[1];
                else if (eret) m_exl = 0;
                if (wen && sel == 5'd14) m_epc = din & ~32'd3;
            end
            if (wen && sel == 5'd12) begin
                m_im = din[15:8];
                m_ie = din[0];
            end
            m_ip = ipn;
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk32("mdl_int_req", {31'h0, int_req}, {31'h0, model_int()});
        chk32("mdl_exl", {31'h0, exl}, {31'h0, m_exl});
        chk32("mdl_epc", epc, m_epc);
        chk32("mdl_dout", dout, model_read(sel));
    endtask

    typedef struct {
        logic [4:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];
    logic [4:0] sels[8];

    initial begin
        tbl[0] = '{5'd12, 32'h0000_FF03, 32'h0000_FF03};
        tbl[1] = '{5'd12, 32'hFFFF_00FE, 32'h0000_0002};
        tbl[2] = '{5'd14, 32'h1234_5677, 32'h1234_5674};
        tbl[3] = '{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        tbl[4] = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{5'd15, 32'h0000_0000, 32'h2007_4411};
        tbl[6] = '{5'd11, 32'h0000_1234, 32'h0000_1234};
        tbl[7] = '{5'd9,  32'h0000_0040, 32'h0000_0040};
        tbl[8] = '{5'd3,  32'hFFFF_FFFF, 32'h0000_0000};
        tbl[9] = '{5'd12, 32'h0000_0000, 32'h0000_0000};
        sels = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};

        rst = 1; pc = 0; din = 0; sel = 5'd11; wen = 0; exc_req = 0; exc_code = 0;
        eret = 0; hwint = 0; din2 = 0; sel2 = 0; wen2 = 0; hwint2 = 0;
        cycle(); cycle();
        rst = 0;
        chk32("rst_compare", dout, 32'hFFFF_FFFF);
        chk32("rst_int_req", {31'h0, int_req}, 32'h0);
        chk32("rst_exl", {31'h0, exl}, 32'h0);
        chk32("rst_epc", epc, 32'h0);
        sel = 5'd9; #1 chk32("rst_count", dout, 32'h0);
        sel = 5'd13; #1 chk32("rst_cause", dout, 32'h0);

        for (int i = 0; i < 10; i++) begin
            wen = 1; sel = tbl[i].s; din = tbl[i].d;
            cycle();
            chk32($sformatf("tbl%0d", i), dout, tbl[i].exp);
            wen = 0;
        end

        // Interrupt entry with misaligned pc.
        wen = 1; sel = 5'd12; din = 32'h0000_0401; cycle(); wen = 0;
        hwint = 6'b000100; pc = 32'h0000_3007; cycle();
        chk32("irq_raise", {31'h0, int_req}, 32'h1);
        cycle();
        chk32("irq_epc", epc, 32'h0000_3004);
        chk32("irq_exl", {31'h0, exl}, 32'h1);
        chk32("irq_int_req_low", {31'h0, int_req}, 32'h0);
        sel = 5'd13; #1 chk32("irq_cause", dout, 32'h0000_0400);

        // Synchronous exception wins exccode over a simultaneous interrupt.
        eret = 1; cycle(); eret = 0;
        chk32("eret_reenable", {31'h0, int_req}, 32'h1);
        exc_req = 1; exc_code = 5'd12; pc = 32'h0000_4000; cycle();
        chk32("exc_cause", dout, 32'h0000_0430);
        chk32("exc_epc", epc, 32'h0000_4000);

        // eret coincident with entry keeps EXL set.
        eret = 1; cycle();
        chk32("eret_vs_entry", {31'h0, exl}, 32'h1);
        exc_req = 0; hwint = 0; cycle(); eret = 0;
        chk32("eret_alone", {31'h0, exl}, 32'h0);
        chk32("eret_no_irq", {31'h0, int_req}, 32'h0);

        // Count wrap and timer interrupt.
        wen = 1; sel = 5'd9; din = 32'hFFFF_FFFE; cycle(); wen = 0;
        chk32("cnt_wr", dout, 32'hFFFF_FFFE);
        cycle(); cycle();
        chk32("cnt_wrap", dout, 32'h0);
        wen = 1; sel = 5'd12; din = 32'h0000_8001; cycle();
        sel = 5'd11; din = 32'd5; cycle(); wen = 0;
        for (int k = 0; k < 10 && !int_req; k++) cycle();
        chk32("tmr_int", {31'h0, int_req}, 32'h1);
        sel = 5'd9; #1 chk32("tmr_count", dout, 32'd7);
        sel = 5'd13;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk32("tmr_ip7_held", {31'h0, dout[15]}, 32'h1);
        end
        wen = 1; sel = 5'd11; din = 32'h100; cycle(); wen = 0; sel = 5'd13; cycle();
        chk32("tmr_ack", {31'h0, dout[15]}, 32'h0);
        wen = 1; sel = 5'd9; din = 32'hFF; cycle(); wen = 0; cycle();
        wen = 1; sel = 5'd11; din = 32'h200; cycle(); wen = 0; sel = 5'd13; cycle();
        chk32("tmr_ack_on_match", {31'h0, dout[15]}, 32'h0);

        // Randomised run against the reference model.
        rst = 1; cycle(); rst = 0;
        for (int n = 0; n < 500; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            hwint    = 6'($urandom);
            exc_req  = ($urandom_range(0, 7) == 0);
            exc_code = 5'($urandom);
            eret     = ($urandom_range(0, 5) == 0);
            wen      = ($urandom_range(0, 2) == 0);
            sel      = sels[$urandom_range(0, 7)];
            din      = $urandom;
            pc       = $urandom;
            if (sel == 5'd11 && $urandom_range(0, 1) == 1) din = m_count + $urandom_range(2, 6);
            if (sel == 5'd12) eret = 0;
            cycle();
        end
        rst = 0; wen = 0; exc_req = 0; eret = 0; hwint = 0;

        // Reduced build: three lines, timer disabled.
        rst = 1; cycle(); rst = 0;
        hwint2 = 3'b111; wen2 = 1; sel2 = 5'd12; din2 = 32'h0000_8001; cycle();
        sel2 = 5'd9; din2 = 32'd0; cycle();
        sel2 = 5'd11; din2 = 32'd3; cycle();
        wen2 = 0; sel2 = 5'd13;
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk32("t0_cause", dout2, 32'h0000_0700);
            chk32("t0_int_req", {31'h0, int_req2}, 32'h0);
        end
        sel2 = 5'd15; #1 chk32("t0_prid", dout2, 32'h2007_4411);
        sel2 = 5'd3;  #1 chk32("t0_sel3", dout2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
